// File: rtl/tmem_pkg.sv
// Shared widths and bus-state encoding for the tagged word memory bus adapter.
// No logic here; imported by the adapter RTL and by benches.
// No flow control of its own.
package tmem_pkg;

   localparam int ADDR_W = 20;   // word address width (1 Mword)
   localparam int WORD_W = 64;   // data word width
   localparam int TAG_W  = 8;    // tag width carried alongside each word

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } bus_state_t;

endpackage

// File: rtl/tmem_bus_adapter_bus_timer.sv
// Wait-cycle counter: cleared by load_i, counts while en_i, flags the last allowed cycle.
// expire_o is combinational from the count register (same-cycle as the count).
// No backpressure; the owner decides what an expiry means.
module bus_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int            CW   = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // next count: load restarts from zero, enable advances by one
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/tmem_bus_adapter.sv
// CPU external bus to tagged word memory adapter with timeout, bad-address and atomic lock.
// Request 1 cycle after rd/wr; read data 1 cycle after mem_ack (min rd-to-data 2 cycles).
// cpu_busy holds off the CPU while a memory transaction is outstanding; rd/wr then ignored.
module tmem_bus_adapter
   import tmem_pkg::*;
#(
   parameter int ADDR_W    = tmem_pkg::ADDR_W,
   parameter int MEM_WORDS = 1048576,
   parameter int TIMEOUT   = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] cpu_ad,
   input  logic [TAG_W-1:0]  cpu_tag,
   input  logic              cpu_astb,
   input  logic              cpu_atomic,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   output logic [WORD_W-1:0] cpu_data,
   output logic [TAG_W-1:0]  cpu_dtag,
   output logic              cpu_busy,
   output logic              mem_req,
   output logic              mem_we,
   output logic              mem_lock,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic [TAG_W-1:0]  mem_wtag,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic [TAG_W-1:0]  mem_rtag,
   output logic              bus_timeout,
   output logic              bad_addr,
   output logic [ADDR_W-1:0] err_addr
);

   // one extra bit so MEM_WORDS == 2**ADDR_W (fully populated) still compares correctly
   localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W + 1)'(MEM_WORDS);

   bus_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic [TAG_W-1:0]  wtag_q, wtag_d;
   logic [WORD_W-1:0] cpu_data_q, cpu_data_d;
   logic [TAG_W-1:0]  cpu_dtag_q, cpu_dtag_d;
   logic              lock_q, lock_d;
   logic              bus_timeout_q, bus_timeout_d;
   logic              bad_addr_q, bad_addr_d;

   logic [ADDR_W-1:0] eff_addr;
   logic              addr_bad;
   logic              tmr_load, tmr_en, tmr_expire;

   // a strobe in the same cycle as rd/wr supplies the address for that access
   assign eff_addr = cpu_astb ? cpu_ad[ADDR_W-1:0] : addr_q;
   assign addr_bad = ({1'b0, eff_addr} >= MEM_LIM);

   bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load_i   (tmr_load),
      .en_i     (tmr_en),
      .expire_o (tmr_expire)
   );

   // next-state and datapath decisions; ack beats a same-cycle expiry
   always_comb begin
      state_d       = state_q;
      addr_d        = eff_addr;
      mem_addr_d    = mem_addr_q;
      err_addr_d    = err_addr_q;
      wdata_d       = wdata_q;
      wtag_d        = wtag_q;
      cpu_data_d    = cpu_data_q;
      cpu_dtag_d    = cpu_dtag_q;
      lock_d        = lock_q;
      bus_timeout_d = 1'b0;
      bad_addr_d    = 1'b0;
      tmr_load      = 1'b0;
      tmr_en        = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_rd || cpu_wr) begin
               if (addr_bad) begin
                  bad_addr_d = 1'b1;
                  err_addr_d = eff_addr;
                  lock_d     = 1'b0;
               end else begin
                  tmr_load   = 1'b1;
                  mem_addr_d = eff_addr;
                  if (cpu_wr) begin
                     state_d = WR_WAIT;
                     wdata_d = cpu_ad;
                     wtag_d  = cpu_tag;
                  end else begin
                     state_d = RD_WAIT;
                     if (cpu_atomic) begin
                        lock_d = 1'b1;
                     end
                  end
               end
            end
         end
         RD_WAIT, WR_WAIT: begin
            if (mem_ack) begin
               state_d = IDLE;
               if (state_q == RD_WAIT) begin
                  cpu_data_d = mem_rdata;
                  cpu_dtag_d = mem_rtag;
               end else begin
                  lock_d = 1'b0;
               end
            end else if (tmr_expire) begin
               state_d       = IDLE;
               bus_timeout_d = 1'b1;
               err_addr_d    = mem_addr_q;
               lock_d        = 1'b0;
            end else begin
               tmr_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // state and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         mem_addr_q    <= '0;
         err_addr_q    <= '0;
         wdata_q       <= '0;
         wtag_q        <= '0;
         cpu_data_q    <= '0;
         cpu_dtag_q    <= '0;
         lock_q        <= 1'b0;
         bus_timeout_q <= 1'b0;
         bad_addr_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         mem_addr_q    <= mem_addr_d;
         err_addr_q    <= err_addr_d;
         wdata_q       <= wdata_d;
         wtag_q        <= wtag_d;
         cpu_data_q    <= cpu_data_d;
         cpu_dtag_q    <= cpu_dtag_d;
         lock_q        <= lock_d;
         bus_timeout_q <= bus_timeout_d;
         bad_addr_q    <= bad_addr_d;
      end
   end

   assign cpu_busy    = (state_q != IDLE);
   assign mem_req     = (state_q != IDLE);
   assign mem_we      = (state_q == WR_WAIT);
   assign mem_lock    = lock_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = wdata_q;
   assign mem_wtag    = wtag_q;
   assign cpu_data    = cpu_data_q;
   assign cpu_dtag    = cpu_dtag_q;
   assign bus_timeout = bus_timeout_q;
   assign bad_addr    = bad_addr_q;
   assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_tmem_bus_adapter.sv
// Directed plus randomized checks of the bus adapter against a transaction-level model.
// Inputs driven 1 time unit after posedge; outputs sampled at the same point.
// Memory side is an ideal responder whose ack delay is chosen per transaction.
module tb_tmem_bus_adapter;
   import tmem_pkg::*;

   localparam int MEMW = 32'h40000;
   localparam int TMO  = 64;

   logic              clk = 1'b0;
   logic              reset;
   logic [WORD_W-1:0] cpu_ad;
   logic [TAG_W-1:0]  cpu_tag;
   logic              cpu_astb, cpu_atomic, cpu_rd, cpu_wr;
   logic [WORD_W-1:0] cpu_data;
   logic [TAG_W-1:0]  cpu_dtag;
   logic              cpu_busy, mem_req, mem_we, mem_lock;
   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic [TAG_W-1:0]  mem_wtag;
   logic              mem_ack;
   logic [WORD_W-1:0] mem_rdata;
   logic [TAG_W-1:0]  mem_rtag;
   logic              bus_timeout, bad_addr;
   logic [ADDR_W-1:0] err_addr;

   tmem_bus_adapter #(.ADDR_W(ADDR_W), .MEM_WORDS(MEMW), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .cpu_ad(cpu_ad), .cpu_tag(cpu_tag), .cpu_astb(cpu_astb),
      .cpu_atomic(cpu_atomic), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_data(cpu_data),
      .cpu_dtag(cpu_dtag), .cpu_busy(cpu_busy), .mem_req(mem_req), .mem_we(mem_we),
      .mem_lock(mem_lock), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wtag(mem_wtag),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_rtag(mem_rtag),
      .bus_timeout(bus_timeout), .bad_addr(bad_addr), .err_addr(err_addr)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state: what the CPU should see
   logic [WORD_W-1:0] data_m;
   logic [TAG_W-1:0]  dtag_m;
   logic [ADDR_W-1:0] err_m;
   logic              lock_m;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cpu();
      cpu_astb   = 1'b0;
      cpu_rd     = 1'b0;
      cpu_wr     = 1'b0;
      cpu_atomic = 1'b0;
   endtask

   // Issue one access and, if it reaches memory, ack it after 'delay' wait cycles.
   task automatic txn(input logic [ADDR_W-1:0] addr, input bit is_wr, input bit both,
                      input bit atomic, input bit same_cyc, input int delay,
                      input logic [63:0] wd_in, input logic [7:0] wt,
                      input logic [63:0] rd, input logic [7:0] rt);
      logic [63:0] wd;
      int          busy_cnt;
      bit          to_seen;
      bit          bad;
      wd       = wd_in;
      busy_cnt = 0;
      to_seen  = 0;
      bad      = (int'(addr) >= MEMW);
      if (!same_cyc) begin
         cpu_astb = 1'b1;
         cpu_ad   = {$urandom, $urandom};
         cpu_ad[ADDR_W-1:0] = addr;
         step();
         cpu_astb = 1'b0;
         cpu_ad   = wd;
      end else begin
         wd[ADDR_W-1:0] = addr;
         cpu_astb = 1'b1;
         cpu_ad   = wd;
      end
      cpu_tag    = wt;
      cpu_wr     = is_wr;
      cpu_rd     = !is_wr || both;
      cpu_atomic = atomic;
      step();
      clear_cpu();
      if (bad) begin
         lock_m = 1'b0;
         err_m  = addr;
         chk("bad_pulse", bad_addr, 1);
         chk("bad_no_req", mem_req, 0);
         chk("bad_busy", cpu_busy, 0);
         chk("bad_err_addr", err_addr, err_m);
         chk("bad_lock", mem_lock, lock_m);
         step();
         chk("bad_single", bad_addr, 0);
         return;
      end
      if (!is_wr && atomic) lock_m = 1'b1;
      chk("req", mem_req, 1);
      chk("we", mem_we, is_wr);
      chk("addr", mem_addr, addr);
      chk("lock_at_req", mem_lock, lock_m);
      if (is_wr) begin
         chk("wdata", mem_wdata, wd);
         chk("wtag", mem_wtag, wt);
      end
      for (int i = 0; i <= delay; i++) begin
         if (cpu_busy) busy_cnt++;
         if (bus_timeout) to_seen = 1;
         if (i == delay) begin
            if (is_wr) chk("lock_at_ack", mem_lock, lock_m);
            mem_ack   = 1'b1;
            mem_rdata = rd;
            mem_rtag  = rt;
         end
         step();
         mem_ack   = 1'b0;
         mem_rdata = {$urandom, $urandom};
         mem_rtag  = 8'($urandom);
      end
      if (is_wr) begin
         lock_m = 1'b0;
      end else begin
         data_m = rd;
         dtag_m = rt;
      end
      chk("busy_cycles", busy_cnt, delay + 1);
      chk("busy_done", cpu_busy, 0);
      chk("req_done", mem_req, 0);
      chk("cpu_data", cpu_data, data_m);
      chk("cpu_dtag", cpu_dtag, dtag_m);
      chk("lock_done", mem_lock, lock_m);
      chk("no_timeout", to_seen | bus_timeout, 0);
   endtask

   // Read that is never acked: expect a timeout TMO cycles after the request rose.
   task automatic txn_timeout(input logic [ADDR_W-1:0] addr, input bit atomic);
      int found;
      found = -1;
      cpu_astb = 1'b1;
      cpu_ad   = 64'(addr);
      step();
      cpu_astb   = 1'b0;
      cpu_rd     = 1'b1;
      cpu_atomic = atomic;
      step();
      clear_cpu();
      if (atomic) lock_m = 1'b1;
      chk("to_req", mem_req, 1);
      chk("to_lock_req", mem_lock, lock_m);
      for (int k = 0; k < TMO + 20 && found < 0; k++) begin
         if (k == TMO - 1) chk("to_req_last", mem_req, 1);
         if (bus_timeout) found = k;
         else step();
      end
      lock_m = 1'b0;
      err_m  = addr;
      chk("to_cycle", found, TMO);
      chk("to_req_drop", mem_req, 0);
      chk("to_busy", cpu_busy, 0);
      chk("to_err_addr", err_addr, err_m);
      chk("to_lock", mem_lock, 0);
      chk("to_data", cpu_data, data_m);
      step();
      chk("to_single", bus_timeout, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_data"}, cpu_data, 0);
      chk({tag, "_dtag"}, cpu_dtag, 0);
      chk({tag, "_busy"}, cpu_busy, 0);
      chk({tag, "_req"}, mem_req, 0);
      chk({tag, "_we"}, mem_we, 0);
      chk({tag, "_lock"}, mem_lock, 0);
      chk({tag, "_addr"}, mem_addr, 0);
      chk({tag, "_wdata"}, mem_wdata, 0);
      chk({tag, "_wtag"}, mem_wtag, 0);
      chk({tag, "_to"}, bus_timeout, 0);
      chk({tag, "_bad"}, bad_addr, 0);
      chk({tag, "_err"}, err_addr, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int seen;
      logic [ADDR_W-1:0] a;
      bit w, bth, at, sc;
      clear_cpu();
      reset     = 1'b1;
      cpu_ad    = '0;
      cpu_tag   = '0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      mem_rtag  = '0;
      data_m = '0; dtag_m = '0; err_m = '0; lock_m = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      chk_all_zero("rst");

      // basic read, ack three cycles after the request
      txn(20'h00123, 0, 0, 0, 0, 3, 64'h0, 8'h0, 64'hDEADBEEF_01234567, 8'h35);
      // write with immediate ack; read data must be untouched
      txn(20'h00040, 1, 0, 0, 0, 0, 64'h5555, 8'h12, 64'h0, 8'h0);
      // no ack: timeout
      txn_timeout(20'h00777, 1'b0);
      // boundary of populated memory
      txn(20'h40000, 0, 0, 0, 0, 0, 64'h0, 8'h0, 64'h0, 8'h0);
      txn(20'h3FFFF, 0, 0, 0, 0, 1, 64'h0, 8'h0, 64'hA5A5_0000_1111_2222, 8'h9C);
      // atomic read-modify-write holds the lock until the write ack
      txn(20'h00200, 0, 0, 1, 0, 2, 64'h0, 8'h0, 64'h0123_4567_89AB_CDEF, 8'h01);
      txn(20'h00200, 1, 0, 0, 0, 1, 64'hFEED_F00D, 8'h02, 64'h0, 8'h0);
      // non-atomic read under lock keeps it; a bad address drops it
      txn(20'h00300, 0, 0, 1, 0, 0, 64'h0, 8'h0, 64'h77, 8'h07);
      txn(20'h00301, 0, 0, 0, 0, 0, 64'h0, 8'h0, 64'h88, 8'h08);
      txn(20'hFFFFF, 1, 0, 0, 0, 0, 64'h1, 8'h1, 64'h0, 8'h0);
      // atomic read that times out releases the lock
      txn_timeout(20'h00010, 1'b1);
      // ack on the last allowed cycle beats the timeout
      txn(20'h00011, 0, 0, 0, 0, TMO - 1, 64'h0, 8'h0, 64'hCAFE, 8'h44);
      // rd and wr together with same-cycle strobe: write wins, new address used
      txn(20'h00abc, 1, 1, 1, 1, 0, 64'h1234_5678_9000_0000, 8'h5A, 64'h0, 8'h0);

      // reset while waiting for a read, then a stale ack
      cpu_astb = 1'b1; cpu_ad = 64'h00500;
      step();
      cpu_astb = 1'b0; cpu_rd = 1'b1; cpu_atomic = 1'b1;
      step();
      clear_cpu();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      data_m = '0; dtag_m = '0; err_m = '0; lock_m = 1'b0;
      chk_all_zero("mid_rst");
      mem_ack = 1'b1; mem_rdata = 64'h1111_2222_3333_4444; mem_rtag = 8'hEE;
      step();
      mem_ack = 1'b0;
      seen = 0;
      for (int i = 0; i < TMO + 8; i++) begin
         if (bus_timeout || cpu_busy || cpu_data != 0) seen = 1;
         step();
      end
      chk("late_ack_ignored", seen, 0);
      chk("late_ack_data", cpu_data, 0);

      // randomized traffic
      for (int n = 0; n < 40; n++) begin
         a   = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(MEMW, 20'hFFFFF))
                                           : ADDR_W'($urandom_range(0, MEMW - 1));
         w   = ($urandom_range(0, 2) == 0);
         bth = ($urandom_range(0, 4) == 0);
         at  = ($urandom_range(0, 2) == 0);
         sc  = ($urandom_range(0, 3) == 0);
         txn(a, w, bth, at, sc, $urandom_range(0, 6), {$urandom, $urandom}, 8'($urandom),
             {$urandom, $urandom}, 8'($urandom));
         if ($urandom_range(0, 1) == 1) step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
